// File: rtl/wbufifo_arb.sv
// Two-requester packet arbiter in front of a wbufifo. It writes whole packets without
// interleaving, tracks the FIFO fill level and inserts keep-alive words while idle.
module wbufifo_arb #(
  parameter int            BW        = 36,
  parameter int            LGFLEN    = 10,
  parameter int            LGIDLE    = 20,
  parameter logic [BW-1:0] IDLE_WORD = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_a_stb,
  input  logic [BW-1:0]     i_a_data,
  input  logic              i_a_last,
  output logic              o_a_busy,
  input  logic              i_b_stb,
  input  logic [BW-1:0]     i_b_data,
  input  logic              i_b_last,
  output logic              o_b_busy,
  output logic              o_wr,
  output logic [BW-1:0]     o_data,
  input  logic              i_fifo_rd,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_err,
  output logic [1:0]        dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

  localparam logic [LGFLEN:0]   FLEN      = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0]   FILL_ONE  = {{LGFLEN{1'b0}}, 1'b1};
  localparam logic [LGIDLE-1:0] IDLE_MAX  = {LGIDLE{1'b1}};
  localparam logic [LGIDLE-1:0] IDLE_ONE  = {{(LGIDLE-1){1'b0}}, 1'b1};

  state_t            state;
  logic              last_b;  // 1 when B owned the most recent completed packet
  logic [LGIDLE-1:0] idle_cnt;
  logic              gnt_a, gnt_b, full, acc_a, acc_b, idle_qual, keep, rd_ok, inc;

  // Grant is resolved combinationally in IDLE so the first word needs no extra cycle.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state)
      IDLE: begin
        if (i_a_stb && (!i_b_stb || last_b)) gnt_a = 1'b1;
        else if (i_b_stb)                     gnt_b = 1'b1;
      end
      OWN_A:   gnt_a = 1'b1;
      OWN_B:   gnt_b = 1'b1;
      default: ;
    endcase
  end

  assign full      = (o_fill == FLEN);
  assign o_a_busy  = !(gnt_a && !full);
  assign o_b_busy  = !(gnt_b && !full);
  assign acc_a     = i_a_stb && !o_a_busy;
  assign acc_b     = i_b_stb && !o_b_busy;
  assign idle_qual = (state == IDLE) && !i_a_stb && !i_b_stb && (o_fill == '0);
  assign keep      = idle_qual && (idle_cnt == IDLE_MAX);
  assign rd_ok     = i_fifo_rd && (o_fill != '0);
  assign inc       = acc_a || acc_b || keep;
  assign o_err     = i_fifo_rd && (o_fill == '0);
  assign dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      o_fill   <= '0;
      idle_cnt <= '0;
      o_wr     <= 1'b0;
      o_data   <= '0;
    end else begin
      o_wr <= inc;
      if (acc_a)      o_data <= i_a_data;
      else if (acc_b) o_data <= i_b_data;
      else if (keep)  o_data <= IDLE_WORD;

      if (acc_a && i_a_last) begin
        state  <= IDLE;
        last_b <= 1'b0;
      end else if (acc_b && i_b_last) begin
        state  <= IDLE;
        last_b <= 1'b1;
      end else if (gnt_a) begin
        state <= OWN_A;
      end else if (gnt_b) begin
        state <= OWN_B;
      end

      // Simultaneous write and read leave the level unchanged.
      if (inc && !rd_ok)      o_fill <= o_fill + FILL_ONE;
      else if (!inc && rd_ok) o_fill <= o_fill - FILL_ONE;

      idle_cnt <= (idle_qual && !keep) ? idle_cnt + IDLE_ONE : '0;
    end
  end
endmodule
